// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding and default widths for the buffered memory stage
package mem_stage_pkg;
    localparam int ADDR_W_D = 32;
    localparam int DATA_W_D = 32;
    localparam int SB_DEPTH_D = 4;
    typedef enum logic [1:0] {IDLE, DRAIN, LOAD} state_e;
endpackage

// File: rtl/store_buffer.sv
// store_buffer: FIFO of pending stores with a youngest-match lookup for forwarding
module store_buffer #(
    parameter int AW = 30,
    parameter int DW = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [AW-1:0]            push_addr,
    input  logic [DW-1:0]            push_data,
    input  logic [AW-1:0]            find_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [AW-1:0]            head_addr,
    output logic [DW-1:0]            head_data,
    output logic                     hit,
    output logic [DW-1:0]            hit_data
);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head, tail;
    // pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop) head <= head + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    // entry storage needs no reset; validity comes from head/count
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= push_addr;
            data_q[tail] <= push_data;
        end
    end
    assign full      = count == (PW+1)'(DEPTH);
    assign head_addr = addr_q[head];
    assign head_data = data_q[head];
    // walk oldest to youngest so the youngest match wins
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++)
            if ((PW+1)'(i) < count && addr_q[head + PW'(i)] == find_addr) begin
                hit      = 1'b1;
                hit_data = data_q[head + PW'(i)];
            end
    end
endmodule

// File: rtl/mem_buffered_stage.sv
// mem_buffered_stage: MEM stage with store buffer, forwarding and a single-port backend
module mem_buffered_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_D,
    parameter int DATA_W = DATA_W_D,
    parameter int SB_DEPTH = SB_DEPTH_D,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_in,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] alu_res,
    input  logic [DATA_W-1:0] val_rm,
    output logic              wb_en_out,
    output logic [DATA_W-1:0] data_mem,
    output logic              ready,
    output logic              be_req,
    output logic              be_we,
    output logic [ADDR_W-3:0] be_addr,
    output logic [DATA_W-1:0] be_wdata,
    input  logic              be_ack,
    input  logic [DATA_W-1:0] be_rdata
);
    state_e state, state_nx;
    logic [ADDR_W-3:0] word, head_addr;
    logic [DATA_W-1:0] head_data, hit_data;
    logic [$clog2(SB_DEPTH):0] count;
    logic full, hit, fwd, miss, push, pop, load_done;
    assign word      = alu_res[ADDR_W-1:2];
    assign fwd       = mem_r_en && (FWD_EN != 0) && hit;
    assign miss      = mem_r_en && !fwd;
    assign push      = rst && mem_w_en && !full;
    assign pop       = state == DRAIN && be_ack;
    assign load_done = state == LOAD && be_ack;
    store_buffer #(.AW(ADDR_W-2), .DW(DATA_W), .DEPTH(SB_DEPTH)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_addr (word),
        .push_data (val_rm),
        .find_addr (word),
        .count     (count),
        .full      (full),
        .head_addr (head_addr),
        .head_data (head_data),
        .hit       (hit),
        .hit_data  (hit_data)
    );
    // state register; reset abandons any backend transfer
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end
    // next state and outputs; a pending load miss outranks draining, reset forces idle outputs
    always_comb begin
        state_nx  = (state == IDLE)  ? (miss ? LOAD : (count != '0 ? DRAIN : IDLE)) :
                    (state == DRAIN) ? (be_ack ? (miss ? LOAD : IDLE) : DRAIN) :
                                       (be_ack ? IDLE : LOAD);
        ready     = !rst || ((!mem_w_en || !full) && (!mem_r_en || fwd || load_done));
        data_mem  = !rst ? '0 : fwd ? hit_data : (mem_r_en && load_done) ? be_rdata : '0;
        be_req    = rst && state != IDLE;
        be_we     = rst && state == DRAIN;
        be_addr   = !rst ? '0 : (state == DRAIN) ? head_addr : (state == LOAD) ? word : '0;
        be_wdata  = (rst && state == DRAIN) ? head_data : '0;
        wb_en_out = wb_en_in && ready;
    end
endmodule

// File: doc/mem_buffered_stage.md
MEM_BUFFERED_STAGE -- requirements
Module: mem_buffered_stage

Interface
REQ-001 Parameter ADDR_W, default 32, is the byte-address width.
REQ-002 Parameter DATA_W, default 32, is the data word width.
REQ-003 Parameter SB_DEPTH, default 4, is the number of store-buffer entries and SHALL be a power of two, at least 2.
REQ-004 Parameter FWD_EN, default 1, enables store-to-load forwarding when 1.
REQ-005 The ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- wb_en_in  in  1  write-back enable from EXE.
- mem_r_en  in  1  load request.
- mem_w_en  in  1  store request.
- alu_res  in  ADDR_W  byte address.
- val_rm  in  DATA_W  store data.
- wb_en_out  out  1  write-back enable to WB.
- data_mem  out  DATA_W  load result.
- ready  out  1  stage may advance; 0 stalls the pipeline.
- be_req  out  1  backend request.
- be_we  out  1  backend write (1) or read (0).
- be_addr  out  ADDR_W-2  backend word address.
- be_wdata  out  DATA_W  backend write data.
- be_ack  in  1  backend completion, one-cycle pulse.
- be_rdata  in  DATA_W  read data, valid with be_ack.

Function
REQ-010 Word address SHALL be alu_res[ADDR_W-1:2]; all matching uses the full word address.
REQ-011 Store buffer SHALL be a FIFO of {word address, data}, head oldest; count ranges 0..SB_DEPTH.
REQ-012 A store SHALL be accepted (enqueued, ready=1, 0 stall) when count<SB_DEPTH, else ready=0 until count<SB_DEPTH.
REQ-013 Full SHALL use the registered count; a pop in the same cycle does not admit a store.
REQ-014 Enqueue and pop in one cycle SHALL leave count unchanged.
REQ-015 Forward hit: with FWD_EN=1, a load whose word address matches any valid entry SHALL return the youngest matching entry's data, ready=1, 0 stall, no backend access.
REQ-016 The forward search SHALL see pre-pop contents, including the head being drained.
REQ-017 A load that does not hit is a miss; ready SHALL be 0 until its read completes.
REQ-018 FSM states are IDLE, DRAIN and LOAD, registered; be_req=1 exactly in DRAIN and LOAD, with be_we=1 in DRAIN.
REQ-019 IDLE SHALL go to LOAD on a load miss, else to DRAIN if count>0, else stay IDLE; a load miss outranks draining.
REQ-020 DRAIN: be_addr/be_wdata SHALL equal the head entry; on be_ack pop the head and go to LOAD if a load miss is present, else IDLE.
REQ-021 LOAD: be_addr SHALL be the load word address; on be_ack data_mem=be_rdata and ready=1 that same cycle, then go to IDLE.
REQ-022 be_addr, be_we and be_wdata SHALL stay stable while be_req=1 and be_ack=0.
REQ-023 The pipeline holds its inputs stable while ready=0.
REQ-024 Minimum load-miss stall is 1 cycle (be_ack in the first LOAD cycle).
REQ-025 wb_en_out SHALL equal wb_en_in when ready=1, else 0.
REQ-026 With no memory operation, ready=1 and data_mem=0.
REQ-027 be_ack outside DRAIN/LOAD SHALL be ignored.

Reset
REQ-030 rst=0 at a clock edge SHALL set state IDLE and count=0, and clear head/tail pointers; buffer contents are don't-care.
REQ-031 Reset mid-DRAIN or mid-LOAD SHALL abandon the transfer and discard buffered stores; be_req=0 the cycle after.
REQ-032 During reset, outputs SHALL be ready=1, wb_en_out=wb_en_in, be_req=0, be_we=0, be_addr=0, be_wdata=0 and data_mem=0.

Structure
REQ-040 Shared package mem_stage_pkg SHALL hold the state enum and the default ADDR_W/DATA_W/SB_DEPTH constants.
REQ-041 The FIFO plus youngest-match search SHALL be sub-module store_buffer; the FSM and muxing stay in mem_buffered_stage.

Verification
REQ-050 Store 0x10<-0xA5A5 then load 0x10 the next cycle -> ready=1 both cycles, data_mem=0xA5A5, no be_req read.
REQ-051 Five stores (SB_DEPTH=4, be_ack held 0) -> first four ready=1, fifth ready=0 until the first DRAIN ack, then accepted.
REQ-052 Stores 0x20<-1 then 0x20<-2, then load 0x20 -> data_mem=2 (youngest wins).
REQ-053 Load miss 0x40, be_ack 3 cycles after be_req with be_rdata=0x1234 -> ready=0 for 3 cycles, then ready=1, data_mem=0x1234, wb_en_out=1.
REQ-054 Load miss arriving mid-DRAIN -> drain completes first, then LOAD with no intervening IDLE.
REQ-055 rst=0 during LOAD with 2 stores buffered -> be_req=0 next cycle; count=0; later load 0x20 misses.
